data_mem_responder: RTL

//  Memory-side responder for the core's load/store port: accepts one request at a time over a

---
 rtl/data_mem_responder_pkg.sv | 14 +
 rtl/data_mem_responder_if.sv | 26 ++
 rtl/data_mem_responder_ram.sv | 32 +++
 rtl/data_mem_responder.sv | 112 +++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the data-memory responder slice.
package mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_BE_W   = 4;

  // Word-aligned and inside the RAM; addr is zero-extended by the caller.
  function automatic logic dmem_addr_ok(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] == 2'b00) && ((addr >> 2) < depth);
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store request and response channels between the core MEM stage and the data RAM.
interface data_mem_responder_if #(parameter int ADDR_W = 16) ();
  import mem_pkg::*;

  logic                   req_valid;
  logic                   req_ready;
  logic                   req_we;
  logic [ADDR_W-1:0]      req_addr;
  logic [DMEM_DATA_W-1:0] req_wdata;
  logic [DMEM_BE_W-1:0]   req_be;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [DMEM_DATA_W-1:0] rsp_rdata;
  logic                   rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/data_mem_responder_ram.sv
// Single-port data RAM with per-byte write enables and a registered read port.
module dmem_ram
  import mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   en,
  input  logic                   we,
  input  logic [IDX_W-1:0]       addr,
  input  logic [DMEM_DATA_W-1:0] wdata,
  input  logic [DMEM_BE_W-1:0]   be,
  output logic [DMEM_DATA_W-1:0] rdata
);

  logic [DMEM_DATA_W-1:0] mem [DEPTH];

  // rdata only moves on a read, so it holds a load result until the next load.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < DMEM_BE_W; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: one outstanding load/store, fixed read latency, held response.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int DEPTH    = 1024,
  parameter int READ_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  data_mem_responder_if.slave bus
);

  // state | meaning
  // IDLE  | ready for a request
  // WAIT  | load accepted, counting down the read latency
  // RESP  | response presented, held until rsp_ready

  localparam int IDX_W = $clog2(DEPTH);

  dmem_state_t       state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic              err_q, err_n;
  logic              load_q, load_n;
  logic              accept, addr_ok;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] ram_rdata;

  assign addr    = bus.req_addr;
  assign accept  = bus.req_valid && (state == IDLE);
  assign addr_ok = dmem_addr_ok(32'(addr), DEPTH);

  dmem_ram #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (addr[IDX_W+1:2]),
    .wdata (bus.req_wdata),
    .be    (bus.req_be),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      err_q  <= 1'b0;
      load_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      err_q  <= err_n;
      load_q <= load_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    err_n   = err_q;
    load_n  = load_q;
    ram_en  = 1'b0;
    ram_we  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!addr_ok) begin
            err_n   = 1'b1;
            state_n = RESP;
          end else if (bus.req_we) begin
            ram_en  = 1'b1;
            ram_we  = 1'b1;
            state_n = RESP;
          end else begin
            ram_en = 1'b1;
            if (READ_LAT == 1) begin
              load_n  = 1'b1;
              state_n = RESP;
            end else begin
              cnt_n   = 4'(READ_LAT - 1);
              state_n = WAIT;
            end
          end
        end
      end
      WAIT: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) begin
          load_n  = 1'b1;
          state_n = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          err_n   = 1'b0;
          load_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // The RAM output register is the load-data latch; load_q gates it so stores/errors read 0.
  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_err   = err_q;
  assign bus.rsp_rdata = load_q ? ram_rdata : '0;

endmodule
